// File: rtl/uart_rx_cfg_if.sv
// Word-side handshake of the configurable UART receiver.
// The receiver is the master and drives the word, flags and valid.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err,
    output frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err,
    input  frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, mid-bit sampling FSM,
// parity/framing checks, break hold-off and a valid/ready word register.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_in,
  output logic          busy,
  uart_rx_cfg_if.master rx_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shr_q, shr_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;
  logic                   tick, half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign tick = (cnt_q == LAST);
  assign half = (cnt_q == HALF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!rxs) state_d = S_START;
      S_START: if (half) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick && idx_q == DLAST)
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR:   if (tick) state_d = S_STOP;
      S_STOP: begin
        if (tick && idx_q == SLAST)
          state_d = rxs ? S_IDLE : S_BRK;
      end
      S_BRK:   if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    shr_d  = shr_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs) begin
          perr_d = 1'b0;
          ferr_d = 1'b0;
        end
      end
      S_START: cnt_d = half ? '0 : cnt_q + 1'b1;
      S_DATA: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          shr_d = {rxs, shr_q[DATA_BITS-1:1]};
          idx_d = (idx_q == DLAST) ? '0 : idx_q + 1'b1;
        end
      end
      S_PAR: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        // odd mode wants the data plus parity bit to XOR to 1
        if (tick)
          perr_d = (PARITY == 1) ? ~(^shr_q ^ rxs) : (^shr_q ^ rxs);
      end
      S_STOP: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          ferr_d = ferr_q | ~rxs;
          idx_d  = (idx_q == SLAST) ? '0 : idx_q + 1'b1;
          done_d = (idx_q == SLAST);
        end
      end
      S_BRK:   cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      shr_q  <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      shr_q  <= shr_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      done_q <= done_d;
    end
  end

  // a completed frame replaces the word only if the slot is free or freed now
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    if (done_q && (!valid_q || rx_if.rx_ready)) begin
      data_d  = shr_q;
      pe_d    = perr_q;
      fe_d    = ferr_q;
      valid_d = 1'b1;
      ovr_d   = 1'b0;
    end else if (done_q) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = pe_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.overrun    = ovr_q;
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver: successor to the fixed 8N1 receiver. Deserialises an asynchronous serial line into parallel words with configurable bit period, data width, parity and stop bits. Adds an input synchroniser, a start-glitch filter, parity and framing error detection, break handling, and a valid/ready output handshake with overrun reporting. It sits between the board-level RX pin and the system-side consumer (FIFO or register interface).

## Interface
- CLKS_PER_BIT, 1250, clk cycles per serial bit; legal range is 8 or more.
- DATA_BITS, 8, data bits per frame; legal range is 5–9; sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- SYNC_STAGES, 2, flip-flops in the rx_in synchroniser; legal range is 2–3.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rx_in  in  1  serial line; idles high.
- rx_data  out  DATA_BITS  received word, LSB = first data bit.
- rx_valid  out  1  rx_data and the error flags are valid.
- rx_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity mismatch for the word being presented; always 0 when PARITY = 0.
- frame_err  out  1  a stop bit was sampled low for the word being presented.
- overrun  out  1  at least one frame was lost since the last acceptance.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- rx_in passes through SYNC_STAGES flip-flops, which reset to 1. All decisions use the synchronised line `rxs`.
- Bit counter `cnt` counts 0..CLKS_PER_BIT-1. HALF is CLKS_PER_BIT/2, using integer division.
- FSM states and transitions:
  - IDLE: `cnt` = 0. If rxs = 0, go to START.
  - START: at `cnt` = HALF, sample rxs.
    - rxs = 1: glitch. Return to IDLE. No flag is raised.
    - rxs = 0: clear `cnt`, clear the bit index, go to DATA.
  - DATA: at `cnt` = CLKS_PER_BIT-1, shift in rxs and clear `cnt`. After DATA_BITS samples, go to PARITY if PARITY ≠ 0, otherwise go to STOP.
  - PARITY: sample at `cnt` = CLKS_PER_BIT-1.
    - Odd mode: error if XOR(data, parity bit) = 0.
    - Even mode: error if XOR(data, parity bit) = 1.
  - STOP: sample each stop bit at `cnt` = CLKS_PER_BIT-1. Any low sample sets the frame error. After the last stop sample, the frame completes. Then:
    - Go to IDLE if the last stop sample was high.
    - Go to BREAK if it was low.
  - BREAK: wait until rxs = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Sampling is mid-bit. START samples at the half period, and every later sample falls one full period after the previous one.
- Frame completion, output register behaviour:
  - If rx_valid = 0, or rx_valid and rx_ready are both high in the same cycle: load rx_data, parity_err and frame_err, and set rx_valid = 1.
  - Otherwise the new frame is discarded. The old word and its flags are held, and overrun is set.
- On rx_valid && rx_ready with no simultaneous completion:
  - rx_valid clears.
  - overrun clears in that same cycle.
- The error flags always describe the currently presented word. They change only when a new word is loaded.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0. The FSM resets to IDLE and `cnt` to 0.
- Reset asserted mid-frame aborts the frame immediately. No partial word is ever presented.
- Let N = DATA_BITS + (PARITY ≠ 0) + STOP_BITS. Latency from the first clk edge at which rx_in = 0 to rx_valid high is exactly SYNC_STAGES + HALF + N·CLKS_PER_BIT + 2 cycles.
- The receiver returns to IDLE one cycle after the final stop sample, so back-to-back frames are accepted. The next start edge may arrive half a bit after the last sample.
- rx_valid stays high until accepted. rx_ready is ignored while rx_valid = 0.
- busy rises one cycle after start detection and falls on entry to IDLE.

## Test plan
1. Defaults with CLKS_PER_BIT = 16, 8N1: send 0xA5 with rx_ready = 1.
   - rx_data = 0xA5 and rx_valid is high for 1 cycle.
   - No error flags.
   - Latency is 2+8+9·16+2 = 156 cycles.
2. Glitch: drive rx_in low for 4 cycles, then high.
   - busy pulses, then the block returns to IDLE.
   - rx_valid stays 0 and no flags are raised.
3. PARITY = 2, DATA_BITS = 7: send 0x35 with correct parity, then 0x35 with the parity bit flipped.
   - First word: parity_err = 0.
   - Second word: parity_err = 1.
   - rx_data = 0x35 both times.
4. Break: hold rx_in low for 30 bit times, then release.
   - One word: rx_data = 0x00, frame_err = 1.
   - No second word until after the line goes high and a new start bit arrives.
5. Overrun: rx_ready = 0, send 0x11 then 0x22.
   - rx_data stays 0x11 and overrun = 1.
   - Pulse rx_ready: rx_valid and overrun clear.
   - Then send 0x33 with rx_ready held high and valid completing in the same cycle: it is loaded and no overrun is raised.
6. STOP_BITS = 2, back-to-back frames 0xFF and 0x00, with reset asserted mid-way through a third frame.
   - Both words are received.
   - After reset, all outputs are 0 and no third word appears.
